alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Downstream stage of ALU32. It captures each ALU result (out, carryout, overflow, zero) together with a destination tag.
- Results are queued in a small FIFO and handed to the writeback consumer over a valid/ready handshake.
- It keeps sticky status flags and a saturating overflow counter, and applies an optional overflow trap that suppresses the faulting result.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 5, destination tag width.
- CNT_W, 8, overflow counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the ALU result and tag are valid this cycle.
- in_ready  output  1  the buffer can accept an entry this cycle.
- alu_out  input  32  ALU32 out.
- alu_carryout  input  1  ALU32 carryout.
- alu_overflow  input  1  ALU32 overflow.
- alu_zero  input  1  ALU32 zero.
- in_tag  input  TAG_W  destination register tag.
- trap_en  input  1  when high, an accepted overflow result is dropped and trap is raised.
- out_valid  output  1  the head entry is valid.
- out_ready  input  1  the consumer accepts the head entry.
- out_data  output  32  head entry result.
- out_tag  output  TAG_W  head entry tag.
- out_flags  output  3  head entry flags, ordered {carry, overflow, zero}.
- sticky_flags  output  3  accumulated {C,V,Z} since the last clear.
- sticky_clr  input  1  clears sticky_flags.
- ovf_count  output  CNT_W  count of accepted overflow results, saturating.
- trap  output  1  one-cycle pulse on a trapped result.

Behaviour:
- Reset, with rst sampled high at an edge:
  - Read/write pointers and count go to 0.
  - out_valid=0, sticky_flags=0, ovf_count=0, trap=0.
  - out_data, out_tag and out_flags read 0 while empty.
  - in_ready is forced to 0 while rst is high.
  - Reset mid-operation discards all queued entries; no partial handshake survives.
- Handshakes:
  - Accept when in_valid and in_ready.
  - Pop when out_valid and out_ready.
  - in_valid must hold its data stable until accepted; out_valid holds the head stable until popped.
- in_ready is 1 when count < DEPTH and rst=0. There is no full-bypass: when full, a pop in the same cycle does not enable a push.
- Push: an accepted entry is written to wr_ptr and count increments, unless it is trapped.
- Latency: an entry accepted at edge k has out_valid=1 in the cycle after edge k. There is no combinational in-to-out path.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full means count == DEPTH; empty means count == 0.
- Trap, when an accepted entry has alu_overflow=1 and trap_en=1:
  - The entry is not pushed and count is unaffected by it.
  - trap=1 for exactly the cycle after the acceptance edge.
  - Back-to-back trapped entries keep trap high on consecutive cycles.
- ovf_count:
  - Increments on every accepted entry with alu_overflow=1, whether trapped or not.
  - Holds at 2^CNT_W-1 once it reaches that value.
- sticky_flags:
  - On each accepted entry: sticky <= (sticky_clr ? 0 : sticky) | {carry, overflow, zero}. Trapped entries are included.
  - When sticky_clr and a new flag arrive in the same cycle, the new flag is set.
- Flags are stored per entry as presented. No reinterpretation of signed/unsigned is done here; that belongs to ALU32.

Decomposition:
- Shared package:
  - FLAG_C=2, FLAG_V=1, FLAG_Z=0 bit indices.
  - A result-entry struct typedef {data[31:0], tag, flags[2:0]}.
  - Default DEPTH, TAG_W and CNT_W constants.
- One sub-module, sync_fifo: a generic DEPTH x width storage with pointers, count, full and empty. The top level holds the trap, sticky and counter logic.

Test Plan:
- Push 5+12 from ALU32 (alu_out=0x00000011, flags 000, tag 3) with out_ready=1.
  - Required: out_valid=1 one cycle later with out_data=0x11, out_tag=3, out_flags=000.
  - Required: the entry pops on the next edge and out_valid returns to 0.
- Hold out_ready=0 and push 5 entries of 0x1..0x5.
  - Required: in_ready drops to 0 after the 4th push.
  - Required: after out_ready rises, entries pop in order 1,2,3,4; the 5th is accepted only after in_ready returns to 1.
- Push alu_out=0x80000000 with overflow=1 and trap_en=1.
  - Required: no entry is queued, trap pulses for 1 cycle, ovf_count=1, sticky_flags[V]=1.
- Repeat with trap_en=0.
  - Required: the entry is queued with out_flags=010 and ovf_count=2.
- Assert sticky_clr in the same cycle as an accepted entry with carry=1 and zero=1, while sticky=010.
  - Required: sticky_flags=101 afterwards.
- Fill with 3 entries, then assert rst for 1 cycle.
  - Required: out_valid=0, count 0, ovf_count=0, in_ready=0 during reset and 1 afterwards.
- Drive 300 overflow accepts.
  - Required: ovf_count saturates at 255.

Source files
------------

// File: rtl/alu_result_buffer_pkg.sv
// Shared definitions for the ALU32 result buffer: flag bit positions,
// default sizing and the queued result-entry layout.
package alu_result_buffer_pkg;

    localparam int DATA_W = 32;

    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_TAG_W = 5;
    localparam int DEFAULT_CNT_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0]        data;
        logic [DEFAULT_TAG_W-1:0] tag;
        logic [2:0]               flags;
    } result_entry_t;

    // Assemble {carry, overflow, zero} in the layout given by the FLAG_* indices.
    function automatic logic [2:0] pack_flags(input logic c, input logic v, input logic z);
        logic [2:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_buffer_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count. Storage is not
// reset; only pointers and count are, so a reset discards every queued entry.
module sync_fifo #(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 8,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [CNT_BITS-1:0] count
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU32 results with a destination tag, queues them for writeback,
// and tracks sticky flags, a saturating overflow count and the overflow trap.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAG_W = DEFAULT_TAG_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_out,
    input  logic              alu_carryout,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              trap_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        out_flags,
    output logic [2:0]        sticky_flags,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              trap
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [2:0]        flags;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam int FCNT_W  = $clog2(DEPTH + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    entry_t            wr_entry;
    entry_t            rd_entry;
    logic [2:0]        in_flags;
    logic              accept;
    logic              trapped;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FCNT_W-1:0] fifo_count;

    logic [2:0]        sticky_p1;
    logic [CNT_W-1:0]  ovf_cnt_p1;
    logic              trap_p1;

    assign in_flags = pack_flags(alu_carryout, alu_overflow, alu_zero);
    assign in_ready = !rst && !full;
    assign accept   = in_valid && in_ready;
    // A trapped overflow is still accepted (handshake completes) but never stored.
    assign trapped  = accept && alu_overflow && trap_en;
    assign push     = accept && !trapped;
    assign pop      = out_valid && out_ready;

    always_comb begin
        wr_entry       = '0;
        wr_entry.data  = alu_out;
        wr_entry.tag   = in_tag;
        wr_entry.flags = in_flags;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // ---- stage p1: head presentation from registered FIFO storage ----
    assign out_valid = !empty;

    // Storage is never reset, so the head is masked to zero while empty.
    always_comb begin
        out_data  = '0;
        out_tag   = '0;
        out_flags = '0;
        if (fifo_count != '0) begin
            out_data  = rd_entry.data;
            out_tag   = rd_entry.tag;
            out_flags = rd_entry.flags;
        end
    end

    // ---- stage p1: status registers updated on acceptance ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_p1  <= '0;
            ovf_cnt_p1 <= '0;
            trap_p1    <= 1'b0;
        end else begin
            trap_p1 <= trapped;
            if (accept) begin
                sticky_p1 <= (sticky_clr ? 3'b000 : sticky_p1) | in_flags;
            end else if (sticky_clr) begin
                sticky_p1 <= '0;
            end
            if (accept && alu_overflow) begin
                ovf_cnt_p1 <= sat_inc(ovf_cnt_p1);
            end
        end
    end

    assign sticky_flags = sticky_p1;
    assign ovf_count    = ovf_cnt_p1;
    assign trap         = trap_p1;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: a queue-based reference model and a
// negedge monitor that compares every presented/popped entry and status output.
module tb_alu_result_buffer;
    import alu_result_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CNT_W = 8;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      alu_out = '0;
    logic             alu_carryout = 1'b0;
    logic             alu_overflow = 1'b0;
    logic             alu_zero = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             trap_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;
    logic [2:0]       sticky_flags;
    logic             sticky_clr = 1'b0;
    logic [CNT_W-1:0] ovf_count;
    logic             trap;

    alu_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_out      (alu_out),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .in_tag       (in_tag),
        .trap_en      (trap_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .ovf_count    (ovf_count),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    result_entry_t exp_q[$];
    int            m_cnt = 0;
    int            m_ovf = 0;
    logic [2:0]    m_sticky = '0;
    logic          m_trap = 1'b0;
    bit            last_acc = 1'b0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO occupancy and status rules in plain arithmetic.
    always @(posedge clk) begin
        bit acc;
        bit trp;
        bit pp;
        if (rst) begin
            exp_q.delete();
            m_cnt    = 0;
            m_ovf    = 0;
            m_sticky = '0;
            m_trap   = 1'b0;
            last_acc = 1'b0;
        end else begin
            acc = in_valid && (m_cnt < DEPTH);
            pp  = (m_cnt > 0) && out_ready;
            trp = acc && alu_overflow && trap_en;
            if (acc && !trp)
                exp_q.push_back(result_entry_t'{data: alu_out, tag: in_tag,
                                                flags: {alu_carryout, alu_overflow, alu_zero}});
            m_cnt  = m_cnt + ((acc && !trp) ? 1 : 0) - (pp ? 1 : 0);
            m_trap = trp;
            if (acc && alu_overflow && m_ovf < OVF_MAX) m_ovf++;
            if (acc) m_sticky = (sticky_clr ? 3'b000 : m_sticky) | {alu_carryout, alu_overflow, alu_zero};
            else if (sticky_clr) m_sticky = 3'b000;
            last_acc = acc;
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        result_entry_t e;
        if (mon_en) begin
            check("in_ready", in_ready, (!rst && m_cnt < DEPTH));
            check("out_valid", out_valid, (m_cnt > 0));
            check("trap", trap, m_trap);
            check("ovf_count", ovf_count, m_ovf);
            check("sticky_flags", sticky_flags, m_sticky);
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pop: got data %0h with no entry expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_tag", out_tag, e.tag);
                        check("out_flags", out_flags, e.flags);
                    end
                end
            end else begin
                check("empty_head", {out_data, out_tag, out_flags}, 64'h0);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] f, input logic [TAG_W-1:0] t,
                        input logic te, input logic clr);
        int k;
        alu_out = d;
        {alu_carryout, alu_overflow, alu_zero} = f;
        in_tag = t;
        trap_en = te;
        sticky_clr = clr;
        in_valid = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!last_acc && k < 50);
        if (!last_acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no acceptance, expected one within 50 cycles");
        end
        in_valid = 1'b0;
        sticky_clr = 1'b0;
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (m_cnt != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (m_cnt != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0", m_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_ready", in_ready, 1);
        check("reset_valid", out_valid, 0);

        // Single result 5+12 = 0x11, consumer always ready.
        out_ready = 1'b1;
        send(32'h11, 3'b000, 5'd3, 1'b0, 1'b0);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'h11);
        check("t1_tag", out_tag, 3);
        @(posedge clk);
        #1;
        check("t1_popped", out_valid, 0);

        // Fill with consumer stalled, then release it for the fifth entry.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(i), 3'b000, 5'(i), 1'b0, 1'b0);
        check("t2_full_ready", in_ready, 0);
        check("t2_head", out_data, 32'h1);
        out_ready = 1'b1;
        send(32'h5, 3'b000, 5'd5, 1'b0, 1'b0);
        drain();

        // Trapped overflow.
        send(32'h8000_0000, 3'b010, 5'd7, 1'b1, 1'b0);
        check("t3_trap", trap, 1);
        check("t3_no_entry", out_valid, 0);
        check("t3_ovf", ovf_count, 1);
        check("t3_sticky_v", sticky_flags[FLAG_V], 1);
        @(posedge clk);
        #1;
        check("t3_trap_pulse", trap, 0);

        // Same overflow, trap disabled: queued.
        out_ready = 1'b0;
        send(32'h8000_0000, 3'b010, 5'd8, 1'b0, 1'b0);
        check("t4_valid", out_valid, 1);
        check("t4_flags", out_flags, 3'b010);
        check("t4_ovf", ovf_count, 2);
        drain();

        // Clear and new flags in the same cycle.
        send(32'h0, 3'b101, 5'd9, 1'b0, 1'b1);
        check("t5_sticky", sticky_flags, 3'b101);
        drain();

        // Reset with three queued entries.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 3'b100, 5'(i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_ovf", ovf_count, 0);
        check("t6_ready", in_ready, 1);

        // 300 back-to-back trapped overflows saturate the counter.
        out_ready = 1'b1;
        alu_out = 32'h7FFF_FFFF;
        {alu_carryout, alu_overflow, alu_zero} = 3'b010;
        trap_en = 1'b1;
        in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t7_ovf_sat", ovf_count, OVF_MAX);
        @(posedge clk);
        #1;

        // Randomized traffic; a pending input is held until accepted.
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                alu_out = $urandom;
                {alu_carryout, alu_overflow, alu_zero} = 3'($urandom);
                in_tag = TAG_W'($urandom);
                trap_en = ($urandom_range(0, 3) == 0);
            end
            sticky_clr = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        sticky_clr = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
